// File: rtl/ps2_rx_fifo.sv
// ============================================================================
//  Module   : ps2_rx_fifo
//  Brief    : PS/2 device-to-host receiver with odd-parity/framing checks,
//             optional E0/F0 prefix folding and a show-ahead code FIFO with
//             fill level and sticky error flags.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_rx_fifo #(
    parameter int DEPTH          = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DECODE         = 1
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    input  logic                     nextdata_n,
    input  logic                     clr_err,
    output logic [7:0]               data,
    output logic                     ext,
    output logic                     brk,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     parity_err,
    output logic                     frame_err
);

    localparam int  ADDR_W = $clog2(DEPTH);
    localparam int  LVL_W  = ADDR_W + 1;
    localparam int  TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam bit  DEC_EN = (DECODE != 0);
    localparam logic [3:0] LAST_BIT = 4'd10;

    // Input synchronisers (idle-high)
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;

    // Frame receiver
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;

    // Decoded code waiting to enter the FIFO: {ext, brk, byte}
    logic             code_vld_q, code_vld_d;
    logic [9:0]       code_q, code_d;

    // FIFO bookkeeping
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [9:0]        mem [DEPTH];

    // Sticky error flags
    logic ovf_q, ovf_d;
    logic par_q, par_d;
    logic frm_q, frm_d;

    // Combinational helpers
    logic        sample;
    logic        din;
    logic [10:0] frame;
    logic [7:0]  rx_byte;
    logic        frm_set;
    logic        par_set;
    logic        ovf_set;
    logic        push;
    logic        pop;
    logic        not_empty;
    logic [9:0]  head;
    logic        unused_sync_tail;

    // The last data-synchroniser stage only keeps the two chains aligned.
    assign unused_sync_tail = dat_sync_q[SYNC_STAGES-1];

    // Next-state logic for receiver, decoder, FIFO pointers and flags
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};

        sample  = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
        din     = dat_sync_q[SYNC_STAGES-2];
        frame   = {din, shift_q};
        rx_byte = frame[8:1];

        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tmo_d      = tmo_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        code_vld_d = 1'b0;
        code_d     = code_q;
        frm_set    = 1'b0;
        par_set    = 1'b0;

        if (sample) begin
            tmo_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = 4'd0;
                if (frame[0] || !frame[10]) begin
                    frm_set = 1'b1;
                end else if (^frame[9:1] != 1'b1) begin
                    par_set = 1'b1;
                end else if (DEC_EN && rx_byte == 8'hE0) begin
                    ext_pend_d = 1'b1;
                end else if (DEC_EN && rx_byte == 8'hF0) begin
                    brk_pend_d = 1'b1;
                end else begin
                    code_vld_d = 1'b1;
                    code_d     = DEC_EN ? {ext_pend_q, brk_pend_q, rx_byte}
                                        : {2'b00, rx_byte};
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shift_d   = {din, shift_q[9:1]};
            end
        end else if (bit_cnt_q != 4'd0) begin
            // A stalled frame is abandoned; the next start bit begins afresh.
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
                bit_cnt_d = 4'd0;
                tmo_d     = '0;
                frm_set   = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        not_empty = (level_q != '0);
        pop       = ~nextdata_n & not_empty;
        push      = code_vld_q & ((level_q != LVL_W'(DEPTH)) | pop);
        ovf_set   = code_vld_q & ~push;

        rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A new error in the clearing cycle still latches.
        ovf_d = ovf_set | (ovf_q & ~clr_err);
        par_d = par_set | (par_q & ~clr_err);
        frm_d = frm_set | (frm_q & ~clr_err);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!clrn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            tmo_q      <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            code_vld_q <= 1'b0;
            code_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            par_q      <= 1'b0;
            frm_q      <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            code_vld_q <= code_vld_d;
            code_q     <= code_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            par_q      <= par_d;
            frm_q      <= frm_d;
        end
    end

    // FIFO storage write port; contents are not reset
    always_ff @(posedge clk) begin
        if (clrn && push) begin
            mem[wr_ptr_q] <= code_q;
        end
    end

    // Show-ahead head entry, forced to zero while the FIFO is empty
    assign head       = mem[rd_ptr_q];
    assign ready      = not_empty;
    assign data       = not_empty ? head[7:0] : 8'h00;
    assign brk        = not_empty & head[8];
    assign ext        = not_empty & head[9];
    assign level      = level_q;
    assign overflow   = ovf_q;
    assign parity_err = par_q;
    assign frame_err  = frm_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
// ============================================================================
//  Module   : tb_ps2_rx_fifo
//  Brief    : Scoreboard bench for ps2_rx_fifo. Two instances (prefix
//             folding on and off) share the PS/2 pins; a behavioural model
//             queues expected codes and a monitor checks every pop.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int SYNC  = 3;
    localparam int TMO   = 200;
    localparam int HALF  = 20;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic clr_err = 1'b0;
    logic nd1 = 1'b1;
    logic nd0 = 1'b1;

    logic [7:0] d1, d0;
    logic       ext1, brk1, rdy1, ovf1, par1, frm1;
    logic       ext0, brk0, rdy0, ovf0, par0, frm0;
    logic [3:0] lvl1, lvl0;

    ps2_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .DECODE(1)) u_dec (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nd1), .clr_err(clr_err), .data(d1), .ext(ext1), .brk(brk1),
        .ready(rdy1), .level(lvl1), .overflow(ovf1), .parity_err(par1), .frame_err(frm1)
    );

    ps2_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .DECODE(0)) u_raw (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nd0), .clr_err(clr_err), .data(d0), .ext(ext0), .brk(brk0),
        .ready(rdy0), .level(lvl0), .overflow(ovf0), .parity_err(par0), .frame_err(frm0)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [9:0] exp1[$];
    logic [9:0] exp0[$];
    bit exp_ovf = 0, exp_par = 0, exp_frm = 0;
    bit ext_p = 0, brk_p = 0;

    // Monitor controls
    bit drain1 = 0;
    bit pop_once = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: choose pop requests, and check every head entry the DUTs hand out
    always @(negedge clk) begin
        nd1 = 1'b1;
        if (pop_once) begin
            nd1 = 1'b0;
            pop_once = 0;
        end else if (drain1) begin
            nd1 = logic'($urandom_range(0, 1));
        end
        nd0 = logic'($urandom_range(0, 1));
        if (clrn && !nd1 && rdy1) begin
            if (exp1.size() == 0) begin
                tests++; fails++;
                $display("FAIL pop_dec: DUT gave %0h but model queue is empty", {ext1, brk1, d1});
            end else begin
                chk("pop_dec", {ext1, brk1, d1}, exp1.pop_front());
            end
        end
        if (clrn && !nd0 && rdy0) begin
            if (exp0.size() == 0) begin
                tests++; fails++;
                $display("FAIL pop_raw: DUT gave %0h but model queue is empty", {ext0, brk0, d0});
            end else begin
                chk("pop_raw", {ext0, brk0, d0}, exp0.pop_front());
            end
        end
    end

    // Expected result of one complete frame, from the protocol rules
    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                               input bit bad_start, input bit sync_pop);
        if (bad_start || bad_stop) begin
            exp_frm = 1;
        end else if (bad_par) begin
            exp_par = 1;
        end else begin
            exp0.push_back({2'b00, b});
            if (b == 8'hE0) begin
                ext_p = 1;
            end else if (b == 8'hF0) begin
                brk_p = 1;
            end else begin
                if (exp1.size() < DEPTH || sync_pop) exp1.push_back({ext_p, brk_p, b});
                else exp_ovf = 1;
                ext_p = 0;
                brk_p = 0;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                              input bit bad_start = 0, input bit sync_pop = 0, input bit chk_lat = 0);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, bad_start};
        model_frame(b, bad_par, bad_stop, bad_start, sync_pop);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF / 2) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                repeat (SYNC) @(posedge clk);
                #1;
                if (chk_lat) chk("latency_early", rdy1, 0);
                if (sync_pop) pop_once = 1;
                @(posedge clk);
                #1;
                if (chk_lat) chk("latency_exact", rdy1, 1);
                repeat (HALF - SYNC - 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_partial(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = (i == 0) ? 1'b0 : logic'($urandom_range(0, 1));
            repeat (HALF / 2) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_ovf"}, ovf1, exp_ovf);
        chk({tag, "_par"}, par1, exp_par);
        chk({tag, "_frm"}, frm1, exp_frm);
        chk({tag, "_raw_ovf"}, ovf0, 0);
        chk({tag, "_raw_par"}, par0, exp_par);
        chk({tag, "_raw_frm"}, frm0, exp_frm);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        exp_ovf = 0; exp_par = 0; exp_frm = 0;
    endtask

    task automatic drain_all(input string tag);
        drain1 = 1;
        repeat (80) @(negedge clk);
        drain1 = 0;
        @(negedge clk);
        chk({tag, "_level_after_drain"}, lvl1, 0);
        chk({tag, "_model_left"}, exp1.size(), 0);
        chk({tag, "_raw_model_left"}, exp0.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, rdy1, 0);
        chk({tag, "_level"}, lvl1, 0);
        chk({tag, "_head"}, {ext1, brk1, d1}, 0);
        chk({tag, "_flags"}, {ovf1, par1, frm1}, 0);
        chk({tag, "_raw_level"}, lvl0, 0);
    endtask

    initial begin
        logic [7:0] b;
        int r;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        clrn = 1'b1;
        settle();

        // Single code, latency, and one-cycle pop
        send_frame(8'h1C, 0, 0, 0, 0, 1);
        settle();
        chk("t1_ready", rdy1, 1);
        chk("t1_head", {ext1, brk1, d1}, {2'b00, 8'h1C});
        chk("t1_level", lvl1, 1);
        @(posedge clk); #1;
        pop_once = 1;
        settle();
        chk("t1_ready_after_pop", rdy1, 0);
        chk("t1_level_after_pop", lvl1, 0);

        // Prefix folding versus raw pass-through
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        settle();
        chk("t2_level", lvl1, 1);
        chk("t2_head", {ext1, brk1, d1}, {2'b11, 8'h75});
        drain_all("t2");

        // Overflow: nine codes into eight entries
        for (int k = 1; k <= 9; k++) send_frame(8'(k));
        settle();
        chk("t3_level_full", lvl1, DEPTH);
        check_flags("t3_full");
        drain_all("t3");
        pulse_clr();
        check_flags("t3_cleared");

        // Parity error, stop-bit error, then a good frame
        send_frame(8'h1C, 1);
        settle();
        check_flags("t4_parity");
        chk("t4_no_push_par", lvl1, 0);
        send_frame(8'h55, 0, 1);
        settle();
        check_flags("t4_stop");
        chk("t4_no_push_stop", lvl1, 0);
        send_frame(8'h32);
        settle();
        chk("t4_good_head", {ext1, brk1, d1}, {2'b00, 8'h32});
        drain_all("t4");
        pulse_clr();

        // Timeout on a stalled frame, then recovery
        send_partial(4);
        repeat (TMO + 60) @(negedge clk);
        exp_frm = 1;
        check_flags("t5_timeout");
        chk("t5_no_push", lvl1, 0);
        send_frame(8'h23);
        settle();
        chk("t5_recover_head", {ext1, brk1, d1}, {2'b00, 8'h23});
        drain_all("t5");
        pulse_clr();

        // Full FIFO with a pop coinciding with the push
        for (int k = 0; k < DEPTH; k++) send_frame(8'h10 + 8'(k));
        settle();
        chk("t6_full", lvl1, DEPTH);
        send_frame(8'h42, 0, 0, 0, 1);
        settle();
        chk("t6_level_kept", lvl1, DEPTH);
        check_flags("t6_no_overflow");
        drain_all("t6");

        // Reset mid-frame drops the partial frame and any pending prefix
        send_frame(8'hE0);
        send_partial(5);
        @(negedge clk);
        clrn = 1'b0;
        exp1.delete(); exp0.delete();
        exp_ovf = 0; exp_par = 0; exp_frm = 0; ext_p = 0; brk_p = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        clrn = 1'b1;
        settle();
        send_frame(8'h29);
        settle();
        chk("midreset_next_head", {ext1, brk1, d1}, {2'b00, 8'h29});
        drain_all("midreset");

        // Randomised traffic with random pops and occasional errors
        drain1 = 1;
        for (int n = 0; n < 40; n++) begin
            b = 8'($urandom);
            r = $urandom_range(0, 9);
            if (r == 2) b = 8'hE0;
            if (r == 3) b = 8'hF0;
            send_frame(b, r == 0, r == 1);
            if (n % 10 == 9) begin
                settle();
                check_flags("rand");
                pulse_clr();
            end
        end
        settle();
        drain_all("rand");
        check_flags("rand_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 device-to-host receiver for keyboard input. It deserialises 11-bit frames, checks start, stop and parity, and optionally folds E0/F0 prefixes into tagged scan codes.
- Received codes are buffered in a DEPTH-entry show-ahead FIFO with true full/empty tracking, fill level, and sticky error flags.
- It sits between the PS/2 pins and the keyboard-to-ASCII / display logic.

Parameters:
- DEPTH, 8: FIFO entries. Must be a power of 2 and at least 2.
- SYNC_STAGES, 3: flops in the ps2_clk/ps2_data synchroniser chains. Must be at least 3.
- TIMEOUT_CYCLES, 50000: number of clk cycles without a ps2_clk falling edge, mid-frame, before the frame is aborted.
- DECODE, 1: 1 folds E0/F0 prefixes into ext/brk tags; 0 passes raw bytes through.

Ports:
- clk, input, 1: system clock. Sole clock.
- clrn, input, 1: synchronous reset, active-low, sampled on clk rising edge.
- ps2_clk, input, 1: PS/2 clock pin (asynchronous).
- ps2_data, input, 1: PS/2 data pin (asynchronous).
- nextdata_n, input, 1: active-low pop request. Level-sensitive: one pop per clk while low and ready is high.
- data, output, 8: scan code at the FIFO head.
- ext, output, 1: head entry was preceded by E0. Always 0 when DECODE=0.
- brk, output, 1: head entry was preceded by F0 (key release). Always 0 when DECODE=0.
- ready, output, 1: FIFO not empty.
- level, output, $clog2(DEPTH)+1: number of entries held, range 0..DEPTH.
- overflow, output, 1: sticky. Set when a code is dropped because the FIFO is full.
- parity_err, output, 1: sticky. Set when a frame fails the odd-parity check.
- frame_err, output, 1: sticky. Set on bad start bit, bad stop bit, or timeout.
- clr_err, input, 1: one-cycle pulse that clears overflow, parity_err and frame_err.

Behaviour:
- Reset (clrn=0 at a clk edge):
  - Cleared to 0: r_ptr, w_ptr, level, bit counter, timeout counter, ext/brk pending flags, and all sticky flags.
  - Outputs after reset: ready=0, level=0.
  - Synchroniser flops reset to 1 (idle-high) so no false edge is seen when reset releases.
  - FIFO storage is not reset.
  - Reset mid-frame discards the partial frame with no error flagged.
- Sampling:
  - s[0] captures ps2_clk; the chain runs to s[SYNC_STAGES-1]. ps2_data runs through an identical chain.
  - Sample pulse = s[N-1] & ~s[N-2], i.e. a ps2_clk falling edge. On the pulse, the synchronised data bit at stage N-2 is taken.
- Frame: bits 0..10 = start(0), D0..D7 (LSB first), parity, stop(1). The bit counter runs 0..10 and returns to 0 after bit 10.
- On bit 10, checks are applied in this priority:
  1. start≠0 or stop≠1 → frame_err set, byte discarded.
  2. XOR(D0..D7, parity)≠1 → parity_err set, byte discarded.
  3. Otherwise the byte is good.
- Timeout:
  - The counter runs while the bit counter ≠0 and clears on every sample pulse.
  - When it reaches TIMEOUT_CYCLES: bit counter←0, frame_err set, partial frame discarded. A frame never resumes mid-way.
- DECODE=1:
  - Good byte E0 → ext_pend←1, nothing pushed.
  - Good byte F0 → brk_pend←1, nothing pushed.
  - Any other good byte → push {ext_pend, brk_pend, byte}, then both pending flags clear.
  - Erroneous frames leave the pending flags unchanged.
- DECODE=0: every good byte is pushed with ext=brk=0.
- Push:
  - Accepted if level<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the code is dropped, overflow is set, and the pending flags clear.
  - Pointers wrap modulo DEPTH.
- Pop:
  - Occurs when nextdata_n=0 and ready=1; r_ptr advances.
  - nextdata_n=0 with ready=0 is ignored.
  - data/ext/brk are combinational from fifo[r_ptr] (show-ahead) and are valid only while ready=1.
- Level: push only +1; pop only −1; push and pop together unchanged. ready = (level≠0).
- Latency: ready rises SYNC_STAGES clk edges after the first edge at which the stop-bit falling ps2_clk is sampled low at s[0].
- Simultaneous push into an empty FIFO with nextdata_n=0: the pop is ignored and the entry stays.
- Sticky flags: clr_err clears all three. If an error event occurs in the same cycle as clr_err, the set wins.

Test Plan:
1. DECODE=1, frame 0x1C (start 0, parity 0, stop 1) → after ~SYNC_STAGES cycles: ready=1, data=0x1C, ext=0, brk=0, level=1. Pulse nextdata_n one cycle → ready=0, level=0.
2. DECODE=1, frames E0, F0, 0x75 → exactly one entry {ext=1, brk=1, data=0x75}. Repeat with DECODE=0 → three entries E0, F0, 75, all with ext=brk=0.
3. DECODE=1, DEPTH=8, send 9 codes without popping → level=8, overflow=1. Pops return codes 1..8 in order; code 9 is absent. Pulse clr_err → overflow=0.
4. Frame 0x1C with parity bit 1 → parity_err=1, no push. Frame with stop bit 0 → frame_err=1, no push. A following good frame 0x32 is received normally.
5. 4 bits of a frame, then ps2_clk held high for TIMEOUT_CYCLES → frame_err=1, bit counter 0. A following full frame 0x23 → data=0x23.
6. FIFO full, nextdata_n held low during the final sample pulse of a new frame → pop and push in the same cycle, level stays DEPTH, overflow=0. Also: assert clrn=0 mid-frame → all outputs 0; the next complete frame decodes correctly.
